// File: rtl/shared_mem_ctrl_pkg.sv
// Shared definitions for the shared instruction/data memory controller:
// FSM state codes, arbitration mode constants and port identifiers.
package shared_mem_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        IFETCH = 2'd1,
        DACC   = 2'd2,
        RESP   = 2'd3
    } state_e;

    typedef enum logic {
        PORT_FETCH = 1'b0,
        PORT_DATA  = 1'b1
    } port_e;

    localparam int ARB_DATA_FIRST = 0;
    localparam int ARB_RR         = 1;

endpackage

// File: rtl/shared_mem_ctrl_sram.sv
// Single-port synchronous byte array with one-cycle registered read.
// The array `mem` is intentionally a plain variable so benches can preload it.
module sram_sp_sync #(
    parameter int BYTE_W = 8,
    parameter int DEPTH  = 512,
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     addr,
    input  logic [BYTE_W-1:0] wdata,
    output logic [BYTE_W-1:0] rdata
);

    logic [BYTE_W-1:0] mem [DEPTH];
    logic [BYTE_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata_q <= mem[addr];
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/shared_mem_ctrl.sv
// Shared instruction-fetch / data load-store controller over one single-port
// byte memory: arbitration, little-endian fetch assembly and write protection.
module shared_mem_ctrl
    import shared_mem_ctrl_pkg::*;
#(
    parameter int BYTE_W    = 8,
    parameter int ADDR_W    = 9,
    parameter int DEPTH     = 512,
    parameter int IF_BYTES  = 2,
    parameter int PROT_BASE = 32,
    parameter int ARB_MODE  = 0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       prot_en,
    input  logic                       i_req,
    input  logic [ADDR_W-1:0]          i_addr,
    output logic                       i_ack,
    output logic [BYTE_W*IF_BYTES-1:0] i_rdata,
    input  logic                       d_req,
    input  logic                       d_we,
    input  logic [ADDR_W-1:0]          d_addr,
    input  logic [BYTE_W-1:0]          d_wdata,
    output logic                       d_ack,
    output logic [BYTE_W-1:0]          d_rdata,
    output logic                       d_err
);

    localparam int MAW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int IW     = BYTE_W * IF_BYTES;
    localparam int BEAT_W = (IF_BYTES > 1) ? $clog2(IF_BYTES) : 1;
    localparam logic [ADDR_W-1:0] LOW_MASK = ADDR_W'((1 << $clog2(IF_BYTES)) - 1);

    function automatic logic [MAW-1:0] wrap_addr(input logic [ADDR_W:0] a);
        logic [ADDR_W:0] r;
        r = a % (ADDR_W+1)'(DEPTH);
        return r[MAW-1:0];
    endfunction

    state_e              state_q, state_d;
    port_e               port_q, port_d, last_q, last_d;
    logic [BEAT_W-1:0]   beat_q, beat_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                we_q, we_d, err_q, err_d;
    logic [BYTE_W-1:0]   wdata_q, wdata_d;
    logic [IW-1:0]       buf_q, buf_d, i_rdata_q, i_rdata_d;
    logic [BYTE_W-1:0]   d_rdata_q, d_rdata_d;

    logic                gnt_data, acc_err, mem_we;
    logic [ADDR_W-1:0]   i_base;
    logic [MAW-1:0]      mem_addr;
    logic [BYTE_W-1:0]   mem_rdata;

    // Data wins unless round-robin says fetch is due.
    assign gnt_data = d_req && (!i_req || (ARB_MODE == ARB_DATA_FIRST) || (last_q == PORT_FETCH));
    assign i_base   = i_addr & ~LOW_MASK;
    assign acc_err  = ({1'b0, d_addr} >= (ADDR_W+1)'(DEPTH)) ||
                      (d_we && prot_en && ({1'b0, d_addr} >= (ADDR_W+1)'(PROT_BASE)));

    // The memory address runs one cycle ahead of the state that consumes the byte.
    always_comb begin
        mem_addr = wrap_addr({1'b0, addr_q});
        case (state_q)
            IDLE:    mem_addr = gnt_data ? wrap_addr({1'b0, d_addr}) : wrap_addr({1'b0, i_base});
            IFETCH:  mem_addr = wrap_addr({1'b0, addr_q} + (ADDR_W+1)'(beat_q) + (ADDR_W+1)'(1));
            default: mem_addr = wrap_addr({1'b0, addr_q});
        endcase
    end

    // Gated by rst_n so a write caught by reset never commits.
    assign mem_we = (state_q == DACC) && we_q && !err_q && rst_n;

    sram_sp_sync #(
        .BYTE_W(BYTE_W),
        .DEPTH (DEPTH)
    ) u_sram (
        .clk  (clk),
        .we   (mem_we),
        .addr (mem_addr),
        .wdata(wdata_q),
        .rdata(mem_rdata)
    );

    always_comb begin
        state_d   = state_q;
        port_d    = port_q;
        last_d    = last_q;
        beat_d    = beat_q;
        addr_d    = addr_q;
        we_d      = we_q;
        wdata_d   = wdata_q;
        err_d     = err_q;
        buf_d     = buf_q;
        i_rdata_d = i_rdata_q;
        d_rdata_d = d_rdata_q;
        case (state_q)
            IDLE: begin
                if (gnt_data) begin
                    state_d = DACC;
                    port_d  = PORT_DATA;
                    last_d  = PORT_DATA;
                    addr_d  = d_addr;
                    we_d    = d_we;
                    wdata_d = d_wdata;
                    err_d   = acc_err;
                end else if (i_req) begin
                    state_d = IFETCH;
                    port_d  = PORT_FETCH;
                    last_d  = PORT_FETCH;
                    addr_d  = i_base;
                    beat_d  = '0;
                    err_d   = 1'b0;
                end
            end
            IFETCH: begin
                buf_d[int'(beat_q)*BYTE_W +: BYTE_W] = mem_rdata;
                if (beat_q == BEAT_W'(IF_BYTES-1)) begin
                    i_rdata_d = buf_d;
                    state_d   = RESP;
                end else begin
                    beat_d = beat_q + BEAT_W'(1);
                end
            end
            DACC: begin
                if (!we_q) begin
                    d_rdata_d = err_q ? '0 : mem_rdata;
                end
                state_d = RESP;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            beat_q    <= '0;
            last_q    <= PORT_DATA;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
        end else begin
            state_q   <= state_d;
            beat_q    <= beat_d;
            last_q    <= last_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
        end
    end

    always_ff @(posedge clk) begin
        port_q  <= port_d;
        addr_q  <= addr_d;
        we_q    <= we_d;
        wdata_q <= wdata_d;
        err_q   <= err_d;
        buf_q   <= buf_d;
    end

    assign i_ack   = (state_q == RESP) && (port_q == PORT_FETCH);
    assign d_ack   = (state_q == RESP) && (port_q == PORT_DATA);
    assign d_err   = d_ack && err_q;
    assign i_rdata = i_rdata_q;
    assign d_rdata = d_rdata_q;

endmodule

// File: tb/tb_shared_mem_ctrl.sv
// Directed bench for shared_mem_ctrl: three instances (defaults; round-robin
// with 4-byte fetch; 256-byte depth) selected one at a time through `sel`.
module tb_shared_mem_ctrl;

    localparam int SA = 0;
    localparam int SB = 1;
    localparam int SC = 2;

    logic       clk = 1'b0;
    logic       rst_n, prot_en, i_req, d_req, d_we;
    logic [8:0] i_addr, d_addr;
    logic [7:0] d_wdata;
    int         sel;

    logic        i_req_a, d_req_a, i_ack_a, d_ack_a, d_err_a;
    logic [15:0] i_rdata_a;
    logic [7:0]  d_rdata_a;
    logic        i_req_b, d_req_b, i_ack_b, d_ack_b, d_err_b;
    logic [31:0] i_rdata_b;
    logic [7:0]  d_rdata_b;
    logic        i_req_c, d_req_c, i_ack_c, d_ack_c, d_err_c;
    logic [15:0] i_rdata_c;
    logic [7:0]  d_rdata_c;

    logic        i_ack, d_ack, d_err;
    logic [31:0] i_rdata;
    logic [7:0]  d_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    int ack_cyc [4];
    bit ack_dat [4];
    int ack_cnt;

    always #5 clk = ~clk;

    assign i_req_a = i_req && (sel == SA);
    assign d_req_a = d_req && (sel == SA);
    assign i_req_b = i_req && (sel == SB);
    assign d_req_b = d_req && (sel == SB);
    assign i_req_c = i_req && (sel == SC);
    assign d_req_c = d_req && (sel == SC);

    always_comb begin
        i_ack = i_ack_a; d_ack = d_ack_a; d_err = d_err_a;
        i_rdata = {16'h0, i_rdata_a}; d_rdata = d_rdata_a;
        if (sel == SB) begin
            i_ack = i_ack_b; d_ack = d_ack_b; d_err = d_err_b;
            i_rdata = i_rdata_b; d_rdata = d_rdata_b;
        end else if (sel == SC) begin
            i_ack = i_ack_c; d_ack = d_ack_c; d_err = d_err_c;
            i_rdata = {16'h0, i_rdata_c}; d_rdata = d_rdata_c;
        end
    end

    shared_mem_ctrl dut_a (
        .clk(clk), .rst_n(rst_n), .prot_en(prot_en),
        .i_req(i_req_a), .i_addr(i_addr), .i_ack(i_ack_a), .i_rdata(i_rdata_a),
        .d_req(d_req_a), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack_a), .d_rdata(d_rdata_a), .d_err(d_err_a)
    );

    shared_mem_ctrl #(.IF_BYTES(4), .ARB_MODE(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .prot_en(prot_en),
        .i_req(i_req_b), .i_addr(i_addr), .i_ack(i_ack_b), .i_rdata(i_rdata_b),
        .d_req(d_req_b), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack_b), .d_rdata(d_rdata_b), .d_err(d_err_b)
    );

    shared_mem_ctrl #(.DEPTH(256)) dut_c (
        .clk(clk), .rst_n(rst_n), .prot_en(prot_en),
        .i_req(i_req_c), .i_addr(i_addr), .i_ack(i_ack_c), .i_rdata(i_rdata_c),
        .d_req(d_req_c), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack_c), .d_rdata(d_rdata_c), .d_err(d_err_c)
    );

    // Fetch from an idle DUT; lat = edges from raising i_req to the ack cycle.
    task automatic do_fetch(input logic [8:0] a, output int lat, output logic [31:0] w);
        i_addr = a; i_req = 1'b1; lat = -1; w = '0;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk); #1;
            if (i_ack) begin lat = n; w = i_rdata; break; end
        end
        i_req = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic do_data(input logic we, input logic [8:0] a, input logic [7:0] wd,
                           output int lat, output logic [7:0] rd, output logic err);
        d_we = we; d_addr = a; d_wdata = wd; d_req = 1'b1; lat = -1; rd = '0; err = 1'b0;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk); #1;
            if (d_ack) begin lat = n; rd = d_rdata; err = d_err; break; end
        end
        d_req = 1'b0;
        @(posedge clk); #1;
    endtask

    // Raise both requests together; with rearm each master re-requests one cycle after its ack.
    task automatic both_reqs(input bit rearm, input int want);
        bit ri, rd;
        ri = 1'b0; rd = 1'b0; ack_cnt = 0;
        i_addr = 9'd32; d_addr = 9'd1; d_we = 1'b0;
        i_req = 1'b1; d_req = 1'b1;
        for (int n = 1; n <= 60; n++) begin
            @(posedge clk); #1;
            if (ri) begin i_req = 1'b1; ri = 1'b0; end
            if (rd) begin d_req = 1'b1; rd = 1'b0; end
            if (i_ack && ack_cnt < 4) begin
                ack_cyc[ack_cnt] = n; ack_dat[ack_cnt] = 1'b0; ack_cnt++;
                i_req = 1'b0; ri = rearm;
            end
            if (d_ack && ack_cnt < 4) begin
                ack_cyc[ack_cnt] = n; ack_dat[ack_cnt] = 1'b1; ack_cnt++;
                d_req = 1'b0; rd = rearm;
            end
            if (ack_cnt >= want) break;
        end
        i_req = 1'b0; d_req = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (i_ack !== 1'b0) begin n_fail++; $display("FAIL reset_i_ack got %b want 0", i_ack); end
        n_checks++; if (d_ack !== 1'b0) begin n_fail++; $display("FAIL reset_d_ack got %b want 0", d_ack); end
        n_checks++; if (d_err !== 1'b0) begin n_fail++; $display("FAIL reset_d_err got %b want 0", d_err); end
        n_checks++; if (i_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_i_rdata got %h want 0", i_rdata); end
        n_checks++; if (d_rdata !== 8'h0) begin n_fail++; $display("FAIL reset_d_rdata got %h want 0", d_rdata); end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_fetch();
        int lat; logic [31:0] w;
        sel = SA;
        do_fetch(9'd32, lat, w);
        n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL fetch32_lat got %0d want 3", lat); end
        n_checks++; if (w !== 32'h5804) begin n_fail++; $display("FAIL fetch32_word got %h want 5804", w); end
        n_checks++; if (i_rdata !== 32'h5804) begin n_fail++; $display("FAIL fetch_hold got %h want 5804", i_rdata); end
        do_fetch(9'd33, lat, w);
        n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL fetch33_lat got %0d want 3", lat); end
        n_checks++; if (w !== 32'h5804) begin n_fail++; $display("FAIL fetch33_word got %h want 5804", w); end
    endtask

    task automatic test_data();
        int lat; logic [7:0] rd; logic err;
        sel = SA; prot_en = 1'b1;
        do_data(1'b1, 9'd1, 8'h3C, lat, rd, err);
        n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL wr1_lat got %0d want 2", lat); end
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL wr1_err got %b want 0", err); end
        do_data(1'b0, 9'd1, 8'h00, lat, rd, err);
        n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL rd1_lat got %0d want 2", lat); end
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL rd1_err got %b want 0", err); end
        n_checks++; if (rd !== 8'h3C) begin n_fail++; $display("FAIL rd1_data got %h want 3c", rd); end
    endtask

    task automatic test_protect();
        int lat; logic [7:0] rd; logic err;
        sel = SA; prot_en = 1'b1;
        do_data(1'b1, 9'd40, 8'hFF, lat, rd, err);
        n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL prot_wr_err got %b want 1", err); end
        n_checks++; if (dut_a.u_sram.mem[40] !== 8'h11) begin n_fail++; $display("FAIL prot_mem got %h want 11", dut_a.u_sram.mem[40]); end
        do_data(1'b0, 9'd40, 8'h00, lat, rd, err);
        n_checks++; if (rd !== 8'h11 || err !== 1'b0) begin n_fail++; $display("FAIL prot_rd got %h/%b want 11/0", rd, err); end
        prot_en = 1'b0;
        do_data(1'b1, 9'd40, 8'hFF, lat, rd, err);
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL unprot_wr_err got %b want 0", err); end
        do_data(1'b0, 9'd40, 8'h00, lat, rd, err);
        n_checks++; if (rd !== 8'hFF || err !== 1'b0) begin n_fail++; $display("FAIL unprot_rd got %h/%b want ff/0", rd, err); end
        prot_en = 1'b1;
    endtask

    task automatic test_arbitration();
        sel = SA;
        both_reqs(1'b0, 2);
        n_checks++; if (ack_cnt !== 2) begin n_fail++; $display("FAIL arb0_count got %0d want 2", ack_cnt); end
        n_checks++; if (ack_dat[0] !== 1'b1 || ack_cyc[0] !== 2) begin n_fail++; $display("FAIL arb0_first got dat=%b cyc=%0d want dat=1 cyc=2", ack_dat[0], ack_cyc[0]); end
        n_checks++; if (ack_dat[1] !== 1'b0 || ack_cyc[1] !== 6) begin n_fail++; $display("FAIL arb0_second got dat=%b cyc=%0d want dat=0 cyc=6", ack_dat[1], ack_cyc[1]); end
        sel = SB;
        both_reqs(1'b1, 4);
        n_checks++; if (ack_cnt !== 4) begin n_fail++; $display("FAIL rr_count got %0d want 4", ack_cnt); end
        n_checks++; if (ack_dat[0] !== 1'b0 || ack_cyc[0] !== 5) begin n_fail++; $display("FAIL rr_g0 got dat=%b cyc=%0d want dat=0 cyc=5", ack_dat[0], ack_cyc[0]); end
        n_checks++; if (ack_dat[1] !== 1'b1 || ack_cyc[1] !== 8) begin n_fail++; $display("FAIL rr_g1 got dat=%b cyc=%0d want dat=1 cyc=8", ack_dat[1], ack_cyc[1]); end
        n_checks++; if (ack_dat[2] !== 1'b0 || ack_cyc[2] !== 14) begin n_fail++; $display("FAIL rr_g2 got dat=%b cyc=%0d want dat=0 cyc=14", ack_dat[2], ack_cyc[2]); end
        n_checks++; if (ack_dat[3] !== 1'b1 || ack_cyc[3] !== 17) begin n_fail++; $display("FAIL rr_g3 got dat=%b cyc=%0d want dat=1 cyc=17", ack_dat[3], ack_cyc[3]); end
    endtask

    task automatic test_wrap_range();
        int lat; logic [31:0] w; logic [7:0] rd; logic err;
        sel = SB;
        do_fetch(9'd508, lat, w);
        n_checks++; if (lat !== 5) begin n_fail++; $display("FAIL wrap_lat got %0d want 5", lat); end
        n_checks++; if (w !== 32'h44332211) begin n_fail++; $display("FAIL wrap_word got %h want 44332211", w); end
        do_fetch(9'd511, lat, w);
        n_checks++; if (w !== 32'h44332211) begin n_fail++; $display("FAIL wrap511_word got %h want 44332211", w); end
        sel = SC; prot_en = 1'b0;
        do_data(1'b0, 9'd44, 8'h00, lat, rd, err);
        n_checks++; if (rd !== 8'h5A || err !== 1'b0) begin n_fail++; $display("FAIL c_rd44 got %h/%b want 5a/0", rd, err); end
        do_data(1'b0, 9'd300, 8'h00, lat, rd, err);
        n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL oor_rd_lat got %0d want 2", lat); end
        n_checks++; if (rd !== 8'h00 || err !== 1'b1) begin n_fail++; $display("FAIL oor_rd got %h/%b want 00/1", rd, err); end
        do_data(1'b1, 9'd300, 8'hA5, lat, rd, err);
        n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL oor_wr_err got %b want 1", err); end
        n_checks++; if (dut_c.u_sram.mem[44] !== 8'h5A) begin n_fail++; $display("FAIL oor_wr_mem got %h want 5a", dut_c.u_sram.mem[44]); end
        prot_en = 1'b1;
    endtask

    task automatic test_reset_mid();
        int lat; logic [31:0] w; logic [7:0] rd; logic err; bit seen;
        sel = SA; prot_en = 1'b1;
        i_addr = 9'd32; i_req = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0; i_req = 1'b0; seen = 1'b0;
        repeat (3) begin @(posedge clk); #1; if (i_ack) seen = 1'b1; end
        n_checks++; if (seen !== 1'b0) begin n_fail++; $display("FAIL rst_fetch_ack got 1 want 0"); end
        n_checks++; if (i_rdata !== 32'h0 || d_rdata !== 8'h0) begin n_fail++; $display("FAIL rst_outs got %h/%h want 0/0", i_rdata, d_rdata); end
        rst_n = 1'b1;
        @(posedge clk); #1;
        d_we = 1'b1; d_addr = 9'd2; d_wdata = 8'h99; d_req = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b0; d_req = 1'b0; seen = 1'b0;
        repeat (3) begin @(posedge clk); #1; if (d_ack) seen = 1'b1; end
        n_checks++; if (seen !== 1'b0) begin n_fail++; $display("FAIL rst_wr_ack got 1 want 0"); end
        n_checks++; if (dut_a.u_sram.mem[2] !== 8'h77) begin n_fail++; $display("FAIL rst_wr_mem got %h want 77", dut_a.u_sram.mem[2]); end
        rst_n = 1'b1;
        @(posedge clk); #1;
        do_data(1'b0, 9'd2, 8'h00, lat, rd, err);
        n_checks++; if (lat !== 2 || rd !== 8'h77) begin n_fail++; $display("FAIL post_rst_rd got lat=%0d data=%h want 2/77", lat, rd); end
        do_fetch(9'd32, lat, w);
        n_checks++; if (lat !== 3 || w !== 32'h5804) begin n_fail++; $display("FAIL post_rst_fetch got lat=%0d word=%h want 3/5804", lat, w); end
    endtask

    initial begin
        rst_n = 1'b0; prot_en = 1'b1; i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
        i_addr = '0; d_addr = '0; d_wdata = '0; sel = SA;
        dut_a.u_sram.mem[2]   = 8'h77;
        dut_a.u_sram.mem[32]  = 8'h04;
        dut_a.u_sram.mem[33]  = 8'h58;
        dut_a.u_sram.mem[40]  = 8'h11;
        dut_b.u_sram.mem[508] = 8'h11;
        dut_b.u_sram.mem[509] = 8'h22;
        dut_b.u_sram.mem[510] = 8'h33;
        dut_b.u_sram.mem[511] = 8'h44;
        dut_c.u_sram.mem[44]  = 8'h5A;
        test_reset();
        test_fetch();
        test_data();
        test_protect();
        test_arbitration();
        test_wrap_range();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/shared_mem_ctrl.md
Name: shared_mem_ctrl

Overview:
Parametrised successor to the single-port byte-wide instruction/data memory used by the serial 8-bit CPU.
- Owns one synchronous single-port byte array shared by an instruction-fetch port and a data load/store port, so the external `is_i_addr` address/data muxing is no longer needed.
- Assembles multi-byte instruction words little-endian: low byte at the lower address.
- Arbitrates between the two ports.
- Write-protects the program region, so a data store can no longer overwrite instructions.

Parameters:
- BYTE_W, 8: width of one memory location and of the data port.
- ADDR_W, 9: byte-address width on both ports.
- DEPTH, 512: number of byte locations implemented; must be ≤ 2^ADDR_W.
- IF_BYTES, 2: bytes per instruction fetch; must be ≥ 1.
- PROT_BASE, 32: lowest protected byte address (program region start = DEFAULT_PC_ADDR*2).
- ARB_MODE, 0: 0 = data port has fixed priority; 1 = round-robin.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- prot_en  in  1  1 = writes at addresses ≥ PROT_BASE are blocked.
- i_req  in  1  instruction fetch request; held high until i_ack.
- i_addr  in  ADDR_W  fetch byte address.
- i_ack  out  1  one-cycle pulse; i_rdata is valid in the same cycle.
- i_rdata  out  BYTE_W*IF_BYTES  assembled instruction word.
- d_req  in  1  data request; held high until d_ack.
- d_we  in  1  1 = write, 0 = read; sampled at acceptance.
- d_addr  in  ADDR_W  data byte address.
- d_wdata  in  BYTE_W  write data.
- d_ack  out  1  one-cycle pulse; d_rdata valid for reads.
- d_rdata  out  BYTE_W  read data.
- d_err  out  1  pulses with d_ack when the access was blocked or out of range.

Behaviour:
- Reset: when rst_n=0 at an edge:
  - state ← IDLE, beat counter ← 0, round-robin pointer ← data;
  - i_ack, d_ack, d_err ← 0; i_rdata, d_rdata ← 0.
  - Memory contents are not cleared.
  - Reset during any access abandons it: no ack is issued, and a pending write that has not yet committed is dropped.
- Acceptance: requests are sampled only in IDLE. Address, d_we and d_wdata are latched at the accepting edge; port inputs are ignored afterwards.
- Arbitration when both requests are high in IDLE:
  - ARB_MODE=0: the data port wins.
  - ARB_MODE=1: the port not served last wins, and the pointer flips after each grant.
  - The losing request stays pending; it is not dropped.
- FSM states:
  - IDLE → IFETCH on i_req grant; IDLE → DACC on d_req grant.
  - IFETCH → RESP after IF_BYTES read cycles.
  - DACC → RESP after 1 cycle.
  - RESP → IDLE.
  - An ack is high only in RESP.
- IFETCH:
  - Base address = i_addr with its low log2(IF_BYTES) bits forced to 0.
  - Beat k (0..IF_BYTES-1) reads byte (base+k) mod DEPTH into i_rdata[k*BYTE_W +: BYTE_W].
- Latencies:
  - i_ack is high in the (IF_BYTES+1)th cycle after the accepting edge; 3 cycles for the defaults.
  - d_ack is high in the 2nd cycle after acceptance, for both reads and writes.
- Writes:
  - Committed at the edge leaving DACC.
  - Suppressed, with d_err=1 at d_ack, if prot_en=1 and address ≥ PROT_BASE, or if address ≥ DEPTH.
- Reads:
  - A data read at address ≥ DEPTH returns 0 with d_err=1.
  - Fetch beats wrap modulo DEPTH and never set an error.
- Handshake:
  - A master must drop req at the edge ending its ack cycle. If req is still high in IDLE, a new access is accepted.
  - Minimum spacing between ack pulses: 3 cycles for data, IF_BYTES+2 cycles for fetch.
- Output holding: i_rdata and d_rdata hold their last value until the next ack on that port.

Decomposition:
- Shared definitions file (alongside DEFINE_CPU.v): FSM state codes (IDLE, IFETCH, DACC, RESP) and ARB_MODE constants (ARB_DATA_FIRST=0, ARB_RR=1).
- One sub-module, sram_sp_sync:
  - parameters BYTE_W and DEPTH; ports clk, we, addr, wdata, rdata;
  - one-cycle synchronous read; array `mem` is hierarchically preloadable.
- Arbiter, FSM and beat assembly live in shared_mem_ctrl.

Test Plan:
1. Fetch assembly: preload mem[32]=0x04, mem[33]=0x58; i_req with i_addr=32 → i_ack exactly 3 cycles after acceptance, i_rdata=0x5804. Repeat with i_addr=33 → same word, since the address is aligned down.
2. Data read/write: write 0x3C to address 1 (prot_en=1), then read address 1 → both d_ack at +2 cycles, d_err=0, d_rdata=0x3C.
3. Protection: prot_en=1, write 0xFF to address 40 → d_ack with d_err=1, mem[40] unchanged. With prot_en=0 the same write succeeds: read-back 0xFF, d_err=0.
4. Simultaneous requests: i_req and d_req raised on the same edge.
   - ARB_MODE=0 → d_ack precedes i_ack, both serviced.
   - ARB_MODE=1 with data served last → i_ack first.
   - Continuous requests on both ports alternate grants.
5. Wrap and range: DEPTH=512, IF_BYTES=4, fetch i_addr=508 → bytes 508..511, no error. Instance with DEPTH=256: data read at 300 → d_rdata=0, d_err=1.
6. Reset mid-operation: assert rst_n=0 during IFETCH beat 1 and during DACC of a write to address 2 → no ack, outputs 0, mem[2] unchanged, next request after reset is serviced normally.
